crc16_checker: RTL and testbench

Receive-side companion to the `crc16` generator. It accepts a frame of 64-bit words plus the 16-bit CRC appended by the transmitter. It recomputes CRC-16/XMODEM over the data words and compares the result against the received CRC. It reports a per-frame pass/fail strobe and keeps a running error count, so the block sits directly behind the link that carries `crc16` output.

---
 rtl/crc16_checker.sv | 106 ++++++++++
 tb/tb_crc16_checker.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_checker.sv
// Receive-side CRC-16/XMODEM checker: folds one 64-bit word per accepted cycle
// and compares the result against the CRC appended by the transmitter.
//
// state | meaning
// IDLE  | waiting for the first word of a frame; CRC restarts from 0x0000
// ACCUM | mid-frame, folding further words into crc_out
// CHECK | one-cycle result slot; done/crc_ok/len_err valid, in_ready low
module crc16_checker #(
    parameter int unsigned MAX_WORDS = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] data_in,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic [15:0] crc_in,
    output logic        in_ready,
    output logic [15:0] crc_out,
    output logic        done,
    output logic        crc_ok,
    output logic        len_err,
    output logic [7:0]  word_cnt,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        CHECK
    } state_t;

    localparam logic [8:0] MAX_W = 9'(MAX_WORDS);

    state_t      state;
    logic        accept;
    logic [15:0] crc_seed;
    logic [15:0] crc_next;
    logic [7:0]  wc_next;
    logic        len_next;
    logic        ok_next;

    function automatic logic [15:0] crc_fold(input logic [15:0] crc_init, input logic [63:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc_init;
        for (int i = 63; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    assign accept   = in_valid && in_ready;
    // A new frame must not inherit the previous frame's final CRC.
    assign crc_seed = (state == IDLE) ? 16'h0000 : crc_out;
    assign crc_next = crc_fold(crc_seed, data_in);
    assign wc_next  = (state == IDLE) ? 8'd1 : ((word_cnt == 8'hFF) ? 8'hFF : word_cnt + 8'd1);
    assign len_next = {1'b0, wc_next} > MAX_W;
    assign ok_next  = (crc_next == crc_in) && !len_next;

    // The verdict is computed on the accepting edge of the last word so that
    // done/crc_ok/len_err are registered and valid throughout the CHECK cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            crc_out  <= 16'h0000;
            done     <= 1'b0;
            crc_ok   <= 1'b0;
            len_err  <= 1'b0;
            word_cnt <= 8'd0;
            err_cnt  <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        crc_out  <= crc_next;
                        word_cnt <= wc_next;
                        if (in_last) begin
                            state    <= CHECK;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            crc_ok   <= ok_next;
                            len_err  <= len_next;
                            if (!ok_next && err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                CHECK: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc16_checker.sv
// Scoreboard bench for crc16_checker: frame verdicts are queued when the last
// word is driven and compared when done pulses.
module tb_crc16_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] data_in;
    logic        in_valid;
    logic        in_last;
    logic [15:0] crc_in;
    logic        in_ready;
    logic [15:0] crc_out;
    logic        done;
    logic        crc_ok;
    logic        len_err;
    logic [7:0]  word_cnt;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    crc16_checker #(.MAX_WORDS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .in_valid (in_valid),
        .in_last  (in_last),
        .crc_in   (crc_in),
        .in_ready (in_ready),
        .crc_out  (crc_out),
        .done     (done),
        .crc_ok   (crc_ok),
        .len_err  (len_err),
        .word_cnt (word_cnt),
        .err_cnt  (err_cnt)
    );

    typedef struct {
        logic [15:0] crc;
        logic        ok;
        logic        len;
        logic [7:0]  wc;
        logic [7:0]  ec;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [63:0] fw[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          done_seen   = 0;
    int          cyc         = 0;
    int          last_accept_cyc;
    logic [7:0]  model_err   = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte-at-a-time reference CRC-16/XMODEM.
    function automatic logic [15:0] model_crc(input logic [15:0] c_in, input logic [63:0] w);
        logic [15:0] c;
        logic [7:0]  byt;
        c = c_in;
        for (int b = 7; b >= 0; b--) begin
            byt = w[b*8 +: 8];
            c   = c ^ {byt, 8'h00};
            for (int k = 0; k < 8; k++) begin
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
            end
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 with no frame outstanding, need none");
            end else begin
                mon_e = sb.pop_front();
                vectors += 5;
                if (crc_out !== mon_e.crc) begin
                    miscompares++;
                    $display("FAIL sb_crc_out: got %h need %h", crc_out, mon_e.crc);
                end
                if (crc_ok !== mon_e.ok) begin
                    miscompares++;
                    $display("FAIL sb_crc_ok: got %b need %b", crc_ok, mon_e.ok);
                end
                if (len_err !== mon_e.len) begin
                    miscompares++;
                    $display("FAIL sb_len_err: got %b need %b", len_err, mon_e.len);
                end
                if (word_cnt !== mon_e.wc) begin
                    miscompares++;
                    $display("FAIL sb_word_cnt: got %0d need %0d", word_cnt, mon_e.wc);
                end
                if (err_cnt !== mon_e.ec) begin
                    miscompares++;
                    $display("FAIL sb_err_cnt: got %0d need %0d", err_cnt, mon_e.ec);
                end
            end
        end
    end

    task automatic send_word(input logic [63:0] d, input logic last, input logic [15:0] c);
        int n;
        data_in  = d;
        in_valid = 1'b1;
        in_last  = last;
        crc_in   = c;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got in_ready=%b for 20 cycles, need 1", in_ready);
        end
        @(posedge clk);
        #1;
        last_accept_cyc = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
        data_in  = 64'h0;
    endtask

    // Sends the words queued in fw; gap idle cycles (with a stray in_last) between words.
    task automatic send_frame(input logic [15:0] c_rx, input int gap);
        exp_t        e;
        logic [15:0] c;
        int          wc;
        c = 16'h0000;
        for (int i = 0; i < fw.size(); i++) c = model_crc(c, fw[i]);
        wc      = (fw.size() > 255) ? 255 : fw.size();
        e.crc   = c;
        e.wc    = 8'(wc);
        e.len   = (wc > 4);
        e.ok    = (c == c_rx) && !e.len;
        if (!e.ok && model_err != 8'hFF) model_err = model_err + 8'd1;
        e.ec    = model_err;
        for (int i = 0; i < fw.size(); i++) begin
            if (i == fw.size() - 1) sb.push_back(e);
            send_word(fw[i], (i == fw.size() - 1), c_rx);
            if (i != fw.size() - 1 && gap > 0) begin
                in_last = 1'b1;
                repeat (gap) @(posedge clk);
                #1;
                in_last = 1'b0;
            end
        end
        vectors += 2;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_done: got %b need 1 one cycle after last word", done);
        end
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL check_in_ready: got %b need 0", in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        data_in = 64'h0;
        crc_in = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            vectors += 7;
            if (crc_out !== 16'h0000) begin miscompares++; $display("FAIL rst_crc_out: got %h need 0000", crc_out); end
            if (done !== 1'b0)        begin miscompares++; $display("FAIL rst_done: got %b need 0", done); end
            if (crc_ok !== 1'b0)      begin miscompares++; $display("FAIL rst_crc_ok: got %b need 0", crc_ok); end
            if (len_err !== 1'b0)     begin miscompares++; $display("FAIL rst_len_err: got %b need 0", len_err); end
            if (word_cnt !== 8'd0)    begin miscompares++; $display("FAIL rst_word_cnt: got %0d need 0", word_cnt); end
            if (err_cnt !== 8'd0)     begin miscompares++; $display("FAIL rst_err_cnt: got %0d need 0", err_cnt); end
            if (in_ready !== 1'b1)    begin miscompares++; $display("FAIL rst_in_ready: got %b need 1", in_ready); end
        end
        vectors++;
        if (done_seen != 0) begin miscompares++; $display("FAIL rst_no_done: got %0d pulses need 0", done_seen); end
    endtask

    task automatic test_single_pass();
        fw = {64'h0000000000000001};
        send_frame(16'h1021, 0);
        vectors += 3;
        if (crc_out !== 16'h1021) begin miscompares++; $display("FAIL single_crc: got %h need 1021", crc_out); end
        if (crc_ok !== 1'b1)      begin miscompares++; $display("FAIL single_ok: got %b need 1", crc_ok); end
        if (word_cnt !== 8'd1)    begin miscompares++; $display("FAIL single_wc: got %0d need 1", word_cnt); end
        repeat (2) @(negedge clk);
        vectors += 4;
        if (crc_out !== 16'h1021) begin miscompares++; $display("FAIL hold_crc: got %h need 1021", crc_out); end
        if (crc_ok !== 1'b1)      begin miscompares++; $display("FAIL hold_ok: got %b need 1", crc_ok); end
        if (word_cnt !== 8'd1)    begin miscompares++; $display("FAIL hold_wc: got %0d need 1", word_cnt); end
        if (done !== 1'b0)        begin miscompares++; $display("FAIL hold_done: got %b need 0", done); end
    endtask

    task automatic test_back_to_back();
        int a_cyc;
        fw = {64'h0, 64'h3};
        send_frame(16'h3063, 1);
        a_cyc = last_accept_cyc;
        vectors += 2;
        if (crc_out !== 16'h3063) begin miscompares++; $display("FAIL stall_crc: got %h need 3063", crc_out); end
        if (word_cnt !== 8'd2)    begin miscompares++; $display("FAIL stall_wc: got %0d need 2", word_cnt); end
        fw = {64'h2};
        send_frame(16'h2042, 0);
        vectors += 2;
        if (last_accept_cyc - a_cyc != 2) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d cycles need 2", last_accept_cyc - a_cyc);
        end
        if (crc_out !== 16'h2042) begin miscompares++; $display("FAIL b2b_crc: got %h need 2042", crc_out); end
    endtask

    task automatic test_bad_crc();
        fw = {64'h1};
        send_frame(16'h1020, 0);
        vectors += 3;
        if (crc_ok !== 1'b0)  begin miscompares++; $display("FAIL bad_ok: got %b need 0", crc_ok); end
        if (len_err !== 1'b0) begin miscompares++; $display("FAIL bad_len: got %b need 0", len_err); end
        if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL bad_err_cnt: got %0d need 1", err_cnt); end
        repeat (300) send_frame(16'h1020, 0);
        @(negedge clk);
        vectors++;
        if (err_cnt !== 8'd255) begin miscompares++; $display("FAIL err_sat: got %0d need 255", err_cnt); end
    endtask

    task automatic test_len_err();
        fw = {64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
        send_frame(16'h0000, 0);
        vectors += 4;
        if (crc_out !== 16'h0000) begin miscompares++; $display("FAIL len_crc: got %h need 0000", crc_out); end
        if (len_err !== 1'b1)     begin miscompares++; $display("FAIL len_flag: got %b need 1", len_err); end
        if (crc_ok !== 1'b0)      begin miscompares++; $display("FAIL len_ok: got %b need 0", crc_ok); end
        if (word_cnt !== 8'd5)    begin miscompares++; $display("FAIL len_wc: got %0d need 5", word_cnt); end
        // Exactly MAX_WORDS words is still legal.
        fw = {64'h0, 64'h0, 64'h0, 64'h1};
        send_frame(16'h1021, 0);
    endtask

    task automatic test_random();
        logic [15:0] c;
        int          n;
        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(1, 6);
            fw = {};
            c = 16'h0000;
            for (int i = 0; i < n; i++) begin
                fw.push_back({$urandom, $urandom});
                c = model_crc(c, fw[i]);
            end
            if ($urandom_range(0, 2) == 0) c = c ^ 16'h0100;
            send_frame(c, $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        send_word(64'h5, 1'b0, 16'h0);
        send_word(64'h6, 1'b0, 16'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_err = 8'd0;
        d0 = done_seen;
        vectors += 3;
        if (err_cnt !== 8'd0)     begin miscompares++; $display("FAIL mid_err_cnt: got %0d need 0", err_cnt); end
        if (word_cnt !== 8'd0)    begin miscompares++; $display("FAIL mid_wc: got %0d need 0", word_cnt); end
        if (crc_out !== 16'h0000) begin miscompares++; $display("FAIL mid_crc: got %h need 0000", crc_out); end
        fw = {64'h1};
        send_frame(16'h1021, 0);
        repeat (3) @(negedge clk);
        vectors += 3;
        if (done_seen - d0 != 1) begin miscompares++; $display("FAIL mid_done_count: got %0d need 1", done_seen - d0); end
        if (crc_ok !== 1'b1)     begin miscompares++; $display("FAIL mid_ok: got %b need 1", crc_ok); end
        if (word_cnt !== 8'd1)   begin miscompares++; $display("FAIL mid_wc_after: got %0d need 1", word_cnt); end
    endtask

    initial begin
        int n;
        test_reset();
        test_single_pass();
        test_back_to_back();
        test_bad_crc();
        test_len_err();
        test_random();
        test_reset_mid();
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d frames outstanding need 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
